// File: rtl/div_unit_if.sv
// ============================================================================
// Module   : div_unit_if
// Purpose  : Request and writeback handshake bundle for the divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_rd;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output req_valid, req_op, req_rd, req_a, req_b, wb_ready,
        input  req_ready, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_a, req_b, wb_ready,
        output req_ready, wb_valid, wb_rd, wb_data
    );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative RV32E DIV/DIVU/REM/REMU unit, restoring division on
//            magnitudes with RADIX_BITS quotient bits resolved per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int RADIX_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    output logic       busy,
    div_unit_if.slave  bus
);

    localparam int         c_STEPS = 32 / RADIX_BITS;
    localparam logic [4:0] c_LAST  = 5'(c_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [3:0]  r_rd;
    logic [31:0] r_q;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [4:0]  r_cnt;
    logic [3:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic        w_signed;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_nxt;
    logic [31:0] w_rem_nxt;
    logic [32:0] w_trial;
    logic        w_last;
    logic [31:0] w_quot;
    logic [31:0] w_remf;
    logic [31:0] w_result;

    // Request decode; flush always wins over a same-cycle accept.
    assign w_accept  = bus.req_valid && (r_state == S_IDLE) && !flush;
    assign w_signed  = !bus.req_op[0];
    assign w_div0    = (bus.req_b == 32'd0);
    assign w_ovf     = w_signed && (bus.req_a == 32'h8000_0000) && (bus.req_b == 32'hFFFF_FFFF);
    assign w_special = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (bus.req_op[1] ? bus.req_a : 32'hFFFF_FFFF)
                                  : (bus.req_op[1] ? 32'd0     : 32'h8000_0000);
    assign w_a_mag   = (w_signed && bus.req_a[31]) ? (32'd0 - bus.req_a) : bus.req_a;
    assign w_b_mag   = (w_signed && bus.req_b[31]) ? (32'd0 - bus.req_b) : bus.req_b;

    // RADIX_BITS restoring steps; dividend bits shift out of r_q MSB-first
    // while quotient bits shift in at the LSB.
    always_comb begin
        w_q_nxt   = r_q;
        w_rem_nxt = r_rem;
        w_trial   = 33'd0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            w_trial = {w_rem_nxt, w_q_nxt[31]};
            w_q_nxt = {w_q_nxt[30:0], 1'b0};
            if (w_trial >= {1'b0, r_div}) begin
                w_trial    = w_trial - {1'b0, r_div};
                w_q_nxt[0] = 1'b1;
            end
            w_rem_nxt = w_trial[31:0];
        end
    end

    assign w_last   = (r_cnt == c_LAST);
    assign w_quot   = r_neg_q ? (32'd0 - w_q_nxt)   : w_q_nxt;
    assign w_remf   = r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;
    assign w_result = r_is_rem ? w_remf : w_quot;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_next = S_DONE;
            S_DONE: if (bus.wb_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rd      <= 4'd0;
            r_q       <= 32'd0;
            r_rem     <= 32'd0;
            r_div     <= 32'd0;
            r_cnt     <= 5'd0;
            r_wb_rd   <= 4'd0;
            r_wb_data <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_rem <= bus.req_op[1];
                r_neg_q  <= w_signed && (bus.req_a[31] ^ bus.req_b[31]);
                r_neg_r  <= w_signed && bus.req_a[31];
                r_rd     <= bus.req_rd;
                r_q      <= w_a_mag;
                r_rem    <= 32'd0;
                r_div    <= w_b_mag;
                r_cnt    <= 5'd0;
                if (w_special) begin
                    r_wb_rd   <= bus.req_rd;
                    r_wb_data <= w_special_res;
                end
            end
            if (r_state == S_CALC && !flush) begin
                r_q   <= w_q_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + 5'd1;
                if (w_last) begin
                    r_wb_rd   <= r_rd;
                    r_wb_data <= w_result;
                end
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.wb_valid  = (r_state == S_DONE);
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_data   = r_wb_data;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Directed scoreboard bench for div_unit (radix 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;
    localparam int RB = 1;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    logic busy;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    div_unit_if dif ();

    div_unit #(.RADIX_BITS(RB)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .busy  (busy),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sbv;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        sa  = $signed(a);
        sbv = $signed(b);
        return op[1] ? 32'(sa % sbv) : 32'(sa / sbv);
    endfunction

    // Drives one request, lets it be accepted, and optionally scoreboards it.
    task automatic send(input logic [1:0] op, input logic [3:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] data, input bit keep, input bit track);
        exp_t e;
        bit   special;
        @(negedge clk);
        dif.req_op = op; dif.req_rd = rd; dif.req_a = a; dif.req_b = b;
        dif.req_valid = 1'b1;
        special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        e.rd = rd; e.data = data; e.lat = special ? 1 : 1 + 32 / RB;
        if (track) sb.push_back(e);
        @(negedge clk);
        if (!keep) dif.req_valid = 1'b0;
    endtask

    // Called on the first sample after the accepting edge.
    task automatic wait_result(input string tag);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (dif.wb_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
        chk({tag, " wb_rd"}, {28'd0, dif.wb_rd}, {28'd0, e.rd});
        chk({tag, " wb_data"}, dif.wb_data, e.data);
        if (dif.wb_ready) begin
            @(negedge clk);
            chk({tag, " wb_valid_drop"}, {31'd0, dif.wb_valid}, 32'd0);
        end
    endtask

    task automatic op_check(input string tag, input logic [1:0] op, input logic [3:0] rd,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] data);
        send(op, rd, a, b, data, 1'b0, 1'b1);
        wait_result(tag);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; flush = 1'b0;
        dif.req_valid = 1'b0; dif.req_op = 2'd0; dif.req_rd = 4'd0;
        dif.req_a = 32'd0; dif.req_b = 32'd0; dif.wb_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset wb_valid", {31'd0, dif.wb_valid}, 32'd0);
        chk("reset wb_rd", {28'd0, dif.wb_rd}, 32'd0);
        chk("reset wb_data", dif.wb_data, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset req_ready", {31'd0, dif.req_ready}, 32'd1);
        rst = 1'b0;

        op_check("div_20_m3",   2'b00, 4'd5, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA);
        op_check("rem_20_m3",   2'b10, 4'd5, 32'd20,         32'hFFFF_FFFD, 32'd2);
        op_check("rem_m20_3",   2'b10, 4'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE);
        op_check("divu_max_2",  2'b01, 4'd1, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF);
        op_check("remu_max_2",  2'b11, 4'd2, 32'hFFFF_FFFF,  32'd2,         32'd1);
        op_check("divu_5_7",    2'b01, 4'd3, 32'd5,          32'd7,         32'd0);
        op_check("remu_5_7",    2'b11, 4'd3, 32'd5,          32'd7,         32'd5);
        op_check("div_by0",     2'b00, 4'd8, 32'd7,          32'd0,         32'hFFFF_FFFF);
        op_check("divu_by0",    2'b01, 4'd8, 32'd7,          32'd0,         32'hFFFF_FFFF);
        op_check("rem_by0",     2'b10, 4'd8, 32'd7,          32'd0,         32'd7);
        op_check("div_ovf",     2'b00, 4'd9, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        op_check("rem_ovf",     2'b10, 4'd9, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        op_check("divu_ovfops", 2'b01, 4'd9, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        op_check("div_rd0",     2'b00, 4'd0, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i % 3 == 0) b = 32'd0 - b;
            op_check("random", op, 4'(i + 1), a, b, model(op, a, b));
        end

        // Backpressure in DONE with a second request waiting.
        dif.wb_ready = 1'b0;
        send(2'b01, 4'd9, 32'd100, 32'd7, 32'd14, 1'b1, 1'b1);
        dif.req_op = 2'b00; dif.req_rd = 4'd7; dif.req_a = 32'd9; dif.req_b = 32'd3;
        wait_result("bp_first");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold wb_valid", {31'd0, dif.wb_valid}, 32'd1);
            chk("bp hold wb_rd", {28'd0, dif.wb_rd}, 32'd9);
            chk("bp hold wb_data", dif.wb_data, 32'd14);
            chk("bp req_ready", {31'd0, dif.req_ready}, 32'd0);
            chk("bp busy", {31'd0, busy}, 32'd1);
        end
        dif.wb_ready = 1'b1;
        @(negedge clk);
        chk("bp release wb_valid", {31'd0, dif.wb_valid}, 32'd0);
        chk("bp release req_ready", {31'd0, dif.req_ready}, 32'd1);
        sb.push_back('{rd: 4'd7, data: 32'd3, lat: 1 + 32 / RB});
        @(negedge clk);
        chk("bp pending busy", {31'd0, busy}, 32'd1);
        chk("bp pending req_ready", {31'd0, dif.req_ready}, 32'd0);
        dif.req_valid = 1'b0;
        wait_result("bp_pending");

        // Flush during CALC iteration 10.
        send(2'b01, 4'd3, 32'd1000, 32'd7, 32'd0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush wb_valid", {31'd0, dif.wb_valid}, 32'd0);
        chk("flush req_ready", {31'd0, dif.req_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dif.wb_valid === 1'b1) seen = 1'b1;
        end
        chk("flush no result", {31'd0, seen}, 32'd0);

        // Flush overrides a same-cycle request in IDLE.
        dif.req_op = 2'b00; dif.req_rd = 4'd2; dif.req_a = 32'd9; dif.req_b = 32'd3;
        dif.req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        dif.req_valid = 1'b0; flush = 1'b0;
        chk("flush blocks accept", {31'd0, busy}, 32'd0);
        op_check("after_flush", 2'b00, 4'd6, 32'd9, 32'd3, 32'd3);

        // Reset mid-CALC also clears the writeback registers.
        send(2'b01, 4'd3, 32'd1000, 32'd7, 32'd0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst wb_valid", {31'd0, dif.wb_valid}, 32'd0);
        chk("rst req_ready", {31'd0, dif.req_ready}, 32'd1);
        chk("rst wb_data", dif.wb_data, 32'd0);
        chk("rst wb_rd", {28'd0, dif.wb_rd}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dif.wb_valid === 1'b1) seen = 1'b1;
        end
        chk("rst no result", {31'd0, seen}, 32'd0);
        op_check("after_rst", 2'b00, 4'd6, 32'd9, 32'd3, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
